// File: rtl/cnn_pkg.sv
// Shared CNN output-stage constants and the writer state encoding.
package cnn_pkg;
    localparam int NUM_CLASSES_DEF = 10;
    localparam int SCORE_WIDTH_DEF = 32;
    localparam int DIGIT_ADDR_DEF  = 0;
    localparam logic [7:0] DIGIT_INVALID = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_WRITE,
        ST_DONE
    } state_t;
endpackage

// File: rtl/argmax_tracker.sv
// Running signed argmax over a score stream; result valid the cycle after the enabled beat.
// Beat 0 loads unconditionally, later beats replace only when strictly greater (ties keep the lowest index).
module argmax_tracker
    import cnn_pkg::*;
#(
    parameter int SCORE_WIDTH = SCORE_WIDTH_DEF,
    parameter int IDX_W       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clr,
    input  logic                          i_en,
    input  logic [IDX_W-1:0]              i_idx,
    input  logic signed [SCORE_WIDTH-1:0] i_data,
    output logic signed [SCORE_WIDTH-1:0] o_max_val,
    output logic [IDX_W-1:0]              o_max_idx
);
    logic signed [SCORE_WIDTH-1:0] r_max_val;
    logic [IDX_W-1:0]              r_max_idx;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_max_val <= '0;
            r_max_idx <= '0;
        end else if (i_en && ((i_idx == '0) || (i_data > r_max_val))) begin
            r_max_val <= i_data;
            r_max_idx <= i_idx;
        end
    end

    assign o_max_val = r_max_val;
    assign o_max_idx = r_max_idx;
endmodule

// File: rtl/predicted_digit_writer.sv
// Argmax of one inference's class scores, written as a byte to predicted_digit_ram (0xFF on a bad stream).
// Write pulses one cycle after the final beat, done one cycle later; score_ready is high only while accumulating.
module predicted_digit_writer
    import cnn_pkg::*;
#(
    parameter int NUM_CLASSES    = NUM_CLASSES_DEF,
    parameter int SCORE_WIDTH    = SCORE_WIDTH_DEF,
    parameter int RAM_ADDR_WIDTH = 4,
    parameter int DIGIT_ADDR     = DIGIT_ADDR_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      score_valid,
    output logic                      score_ready,
    input  logic [SCORE_WIDTH-1:0]    score_data,
    input  logic                      score_last,
    output logic                      ram_we,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]                ram_wdata,
    output logic [3:0]                predicted_digit,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    localparam int IDX_W = $clog2(NUM_CLASSES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t r_state, w_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_error;
    logic [3:0]       r_digit;

    logic w_accept, w_end, w_bad, w_clr;
    logic signed [SCORE_WIDTH-1:0] w_max_val;
    logic [IDX_W-1:0]              w_max_idx;
    logic [3:0]                    w_digit;

    argmax_tracker #(
        .SCORE_WIDTH(SCORE_WIDTH),
        .IDX_W      (IDX_W)
    ) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clr),
        .i_en     (w_accept),
        .i_idx    (r_idx),
        .i_data   (score_data),
        .o_max_val(w_max_val),
        .o_max_idx(w_max_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        score_ready = 1'b0;
        ram_we      = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        w_clr       = 1'b0;
        w_accept    = 1'b0;
        w_end       = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_clr  = 1'b1;
                    w_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                score_ready = 1'b1;
                w_accept    = score_valid;
                // Stream ends on last, or is forced to end once the final class index arrives without it.
                if (w_accept) begin
                    if (score_last) begin
                        w_end = 1'b1;
                        w_bad = (r_idx != LAST_IDX);
                    end else if (r_idx == LAST_IDX) begin
                        w_end = 1'b1;
                        w_bad = 1'b1;
                    end
                end
                if (w_end) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                ram_we = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_error <= 1'b0;
            r_digit <= 4'h0;
        end else begin
            if (w_clr) begin
                r_idx   <= '0;
                r_error <= 1'b0;
            end else if (w_accept && !w_end) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_bad)  r_error <= 1'b1;
            if (ram_we) r_digit <= ram_wdata[3:0];
        end
    end

    assign w_digit         = 4'(w_max_idx);
    assign ram_wdata       = ram_we ? (r_error ? DIGIT_INVALID : {4'h0, w_digit}) : 8'h00;
    assign ram_addr        = RAM_ADDR_WIDTH'(DIGIT_ADDR);
    assign predicted_digit = r_digit;
    assign error           = r_error;

    a_first_beat_loads: assert property (@(posedge clk) disable iff (rst)
        (w_accept && (r_idx == '0)) |=> (w_max_val == $past(score_data)));
endmodule

// File: tb/tb_predicted_digit_writer.sv
// Directed bench for predicted_digit_writer: argmax, signed compare, stream-length errors, gaps and reset.
module tb_predicted_digit_writer;
    logic        clk = 1'b0;
    logic        rst, start, score_valid, score_last;
    logic [31:0] score_data;
    logic        score_ready, ram_we, busy, done, error;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [3:0]  predicted_digit;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    logic signed [31:0] r_sc [10];

    predicted_digit_writer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .score_valid    (score_valid),
        .score_ready    (score_ready),
        .score_data     (score_data),
        .score_last     (score_last),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .predicted_digit(predicted_digit),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we === 1'b1) we_cnt++;
        if (done === 1'b1)   done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (score_ready !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL start_ready: got ready=%b busy=%b want 1 1", score_ready, busy);
        end
    endtask

    task automatic feed(input int nbeats, input int last_pos, input bit gaps);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 3);
                repeat (g) begin
                    score_valid = 1'b0;
                    start = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                start = 1'b0;
            end
            score_valid = 1'b1;
            score_data  = r_sc[i];
            score_last  = (i == last_pos);
            total++;
            if (score_ready !== 1'b1) begin
                bad++;
                $display("FAIL feed_ready beat %0d: got %b want 1", i, score_ready);
            end
            @(posedge clk); #1;
        end
        score_valid = 1'b0;
        score_last  = 1'b0;
        start       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; score_valid = 1'b0; score_last = 1'b0; score_data = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({score_ready, ram_we, busy, done, error} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 00000", {score_ready, ram_we, busy, done, error});
        end
        total++;
        if (ram_wdata !== 8'h00 || predicted_digit !== 4'h0 || ram_addr !== 4'h0) begin
            bad++;
            $display("FAIL reset_data: got wdata=%h digit=%h addr=%h want 00 0 0", ram_wdata, predicted_digit, ram_addr);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Runs one full inference and checks the write/done/idle timeline.
    task automatic test_stream(input string name, input int nbeats, input int last_pos, input bit gaps,
                               input logic [7:0] exp_wdata, input logic exp_err);
        we_cnt = 0; done_cnt = 0;
        do_start();
        feed(nbeats, last_pos, gaps);
        total++;
        if (ram_we !== 1'b1 || score_ready !== 1'b0 || ram_wdata !== exp_wdata || ram_addr !== 4'h0) begin
            bad++;
            $display("FAIL %s_write: got we=%b rdy=%b wdata=%h addr=%h want 1 0 %h 0", name, ram_we, score_ready, ram_wdata, ram_addr, exp_wdata);
        end
        total++;
        if (error !== exp_err) begin
            bad++;
            $display("FAIL %s_error: got %b want %b", name, error, exp_err);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b1 || ram_we !== 1'b0 || predicted_digit !== exp_wdata[3:0]) begin
            bad++;
            $display("FAIL %s_done: got done=%b we=%b digit=%h want 1 0 %h", name, done, ram_we, predicted_digit, exp_wdata[3:0]);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || we_cnt != 1 || done_cnt != 1) begin
            bad++;
            $display("FAIL %s_idle: got busy=%b done=%b writes=%0d dones=%0d want 0 0 1 1", name, busy, done, we_cnt, done_cnt);
        end
    endtask

    task automatic test_basic();
        r_sc = '{-5, 3, 7, 2, 7, -1, 0, 6, 1, 4};
        test_stream("basic", 10, 9, 1'b0, 8'h02, 1'b0);
    endtask

    task automatic test_negative();
        for (int i = 0; i < 10; i++) r_sc[i] = -100;
        r_sc[9] = -1;
        test_stream("negative", 10, 9, 1'b0, 8'h09, 1'b0);
    endtask

    task automatic test_early_last();
        r_sc = '{-5, 3, 7, 2, 7, -1, 0, 6, 1, 4};
        test_stream("early", 7, 6, 1'b0, 8'hFF, 1'b1);
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL early_sticky: got %b want 1", error);
        end
        do_start();
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL early_clear: got %b want 0", error);
        end
        feed(10, 9, 1'b0);
        total++;
        if (ram_we !== 1'b1 || ram_wdata !== 8'h02) begin
            bad++;
            $display("FAIL early_recover: got we=%b wdata=%h want 1 02", ram_we, ram_wdata);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_missing_last();
        r_sc = '{-5, 3, 7, 2, 7, -1, 0, 6, 1, 4};
        we_cnt = 0;
        do_start();
        feed(10, -1, 1'b0);
        total++;
        if (ram_we !== 1'b1 || ram_wdata !== 8'hFF || score_ready !== 1'b0 || error !== 1'b1) begin
            bad++;
            $display("FAIL missing_write: got we=%b wdata=%h rdy=%b err=%b want 1 ff 0 1", ram_we, ram_wdata, score_ready, error);
        end
        score_valid = 1'b1; score_data = 32'd123; score_last = 1'b1;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b1 || predicted_digit !== 4'hF || score_ready !== 1'b0) begin
            bad++;
            $display("FAIL missing_done: got done=%b digit=%h rdy=%b want 1 f 0", done, predicted_digit, score_ready);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || score_ready !== 1'b0) begin
            bad++;
            $display("FAIL missing_idle: got busy=%b rdy=%b want 0 0", busy, score_ready);
        end
        score_valid = 1'b0; score_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (we_cnt != 1) begin
            bad++;
            $display("FAIL missing_writes: got %0d want 1", we_cnt);
        end
    endtask

    task automatic test_gaps();
        r_sc = '{-5, 3, 7, 2, 7, -1, 0, 6, 1, 4};
        test_stream("gaps", 10, 9, 1'b1, 8'h02, 1'b0);
    endtask

    task automatic test_rst_mid();
        r_sc = '{-5, 3, 7, 2, 7, -1, 0, 6, 1, 4};
        we_cnt = 0; done_cnt = 0;
        do_start();
        feed(6, -1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({score_ready, ram_we, busy, done, error} !== 5'b0 || ram_wdata !== 8'h00 || predicted_digit !== 4'h0) begin
            bad++;
            $display("FAIL rstmid_outputs: got ctl=%b wdata=%h digit=%h want 00000 00 0",
                     {score_ready, ram_we, busy, done, error}, ram_wdata, predicted_digit);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (we_cnt != 0 || done_cnt != 0) begin
            bad++;
            $display("FAIL rstmid_silent: got writes=%0d dones=%0d want 0 0", we_cnt, done_cnt);
        end
        test_stream("after_rst", 10, 9, 1'b0, 8'h02, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_early_last();
        test_missing_last();
        test_gaps();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
